// File: rtl/branch_pc_unit.sv
// Fetch PC generator with branch/jump resolution, redirect flush FSM and
// optional branch statistics (enabled by defining BRANCH_STATS_EN).
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h4000_0000,
  parameter int          FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic        breq,
  input  logic        brlt,
  input  logic [31:0] ex_target,
  output logic        brun,
  output logic [31:0] pc,
  output logic        flush,
  output logic        redirect,
  output logic        misalign,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_DEPTH);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic [31:0] r_pc;
  logic        w_taken;
  logic        w_in_run;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_unused_bits;

  assign brun     = ex_funct3[1];
  assign w_in_run = (r_state == RUN);

  always_comb begin
    w_taken = 1'b0;
    case (ex_funct3)
      3'b000:          w_taken = breq;
      3'b001:          w_taken = ~breq;
      3'b100, 3'b110:  w_taken = brlt;
      3'b101, 3'b111:  w_taken = ~brlt;
      default:         w_taken = 1'b0;
    endcase
  end

  // Transfers seen while flushing belong to squashed instructions, and
  // nothing resolves during reset.
  assign w_redirect = ~rst & ex_valid & w_in_run &
                      (ex_is_jal | ex_is_jalr | (ex_is_branch & w_taken));
  assign w_target   = {ex_target[31:2], 2'b00};
  assign w_unused_bits = ex_target[0];

  assign redirect = w_redirect;
  assign misalign = w_redirect & ex_target[1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_redirect) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (!stall) begin
          if (r_cnt == 2'd1) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = 2'd0;
          end else begin
            w_cnt_nxt   = r_cnt - 2'd1;
          end
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Redirect wins over stall so a resolved transfer is never lost.
  always_ff @(posedge clk) begin
    if (rst)
      r_pc <= RESET_PC;
    else if (w_redirect)
      r_pc <= w_target;
    else if (!stall)
      r_pc <= r_pc + 32'd4;
  end

  assign pc    = r_pc;
  assign flush = (r_state == FLUSH);

`ifdef BRANCH_STATS_EN
  logic [31:0] r_br_count;
  logic [31:0] r_br_taken_count;
  logic        w_br_seen;

  assign w_br_seen = ex_valid & ex_is_branch & w_in_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_count       <= 32'd0;
      r_br_taken_count <= 32'd0;
    end else if (w_br_seen) begin
      r_br_count <= r_br_count + 32'd1;
      if (w_taken)
        r_br_taken_count <= r_br_taken_count + 32'd1;
    end
  end

  assign br_count       = r_br_count;
  assign br_taken_count = r_br_taken_count;
`else
  assign br_count       = 32'd0;
  assign br_taken_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: reset, branch/jump redirects, flush
// timing under stall, reset during flush and statistics counters.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic        breq, brlt;
  logic [31:0] ex_target;
  logic        brun, flush, redirect, misalign;
  logic [31:0] pc, br_count, br_taken_count;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  branch_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .breq(breq), .brlt(brlt), .ex_target(ex_target),
    .brun(brun), .pc(pc), .flush(flush), .redirect(redirect), .misalign(misalign),
    .br_count(br_count), .br_taken_count(br_taken_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = 3'b000; breq = 0; brlt = 0; ex_target = 32'h0;
  endtask

  task automatic ex(input logic br, input logic jal, input logic jalr,
                    input logic [2:0] f3, input logic eq, input logic lt,
                    input logic [31:0] tgt);
    ex_valid = 1; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; breq = eq; brlt = lt; ex_target = tgt;
    #1;
  endtask

  task automatic chk_stats(input string tag, input int c, input int t);
    check({tag, "_brcnt"}, br_count, STATS ? 32'(c) : 32'd0);
    check({tag, "_tkcnt"}, br_taken_count, STATS ? 32'(t) : 32'd0);
  endtask

  initial begin
    rst = 1; stall = 0; idle();
    tick(); tick();
    rst = 0; #1;
    check("rst_pc", pc, 32'h4000_0000);
    check("rst_flush", {31'd0, flush}, 32'd0);
    chk_stats("rst", 0, 0);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("free_pc%0d", i), pc, 32'h4000_0000 + 32'(4 * i));
      check($sformatf("free_flush%0d", i), {31'd0, flush}, 32'd0);
      tick();
    end

    // BGEU, brlt=1: unsigned compare, not taken
    ex(1, 0, 0, 3'b111, 0, 1, 32'h4000_0500);
    check("bgeu_brun", {31'd0, brun}, 32'd1);
    check("bgeu_redir", {31'd0, redirect}, 32'd0);
    tick(); idle();
    check("bgeu_pc", pc, 32'h4000_0014);
    chk_stats("bgeu", 1, 0);

    // BLT taken
    ex(1, 0, 0, 3'b100, 0, 1, 32'h4000_0100);
    check("blt_redir", {31'd0, redirect}, 32'd1);
    check("blt_brun", {31'd0, brun}, 32'd0);
    tick(); idle(); #1;
    check("blt_pc", pc, 32'h4000_0100);
    check("blt_fl1", {31'd0, flush}, 32'd1);
    chk_stats("blt", 2, 1);
    tick();
    check("blt_pc2", pc, 32'h4000_0104);
    check("blt_fl2", {31'd0, flush}, 32'd1);
    tick();
    check("blt_pc3", pc, 32'h4000_0108);
    check("blt_fl3", {31'd0, flush}, 32'd0);

    // JALR with bit1 set, then a JAL during flush that must be ignored
    ex(0, 0, 1, 3'b000, 0, 0, 32'h4000_0203);
    check("jalr_redir", {31'd0, redirect}, 32'd1);
    check("jalr_mis", {31'd0, misalign}, 32'd1);
    tick();
    ex(0, 1, 0, 3'b000, 0, 0, 32'h4000_0802);
    check("jalr_pc", pc, 32'h4000_0200);
    check("jalr_fl", {31'd0, flush}, 32'd1);
    check("jal_ign_redir", {31'd0, redirect}, 32'd0);
    check("jal_ign_mis", {31'd0, misalign}, 32'd0);
    tick(); idle();
    check("jal_ign_pc", pc, 32'h4000_0204);
    chk_stats("jalr", 2, 1);
    tick(); tick();
    check("jalr_done_fl", {31'd0, flush}, 32'd0);
    check("jalr_done_pc", pc, 32'h4000_020C);

    // Redirect while stalled, flush frozen for three stalled cycles
    stall = 1;
    ex(0, 1, 0, 3'b000, 0, 0, 32'h4000_0300);
    check("stl_redir", {31'd0, redirect}, 32'd1);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stl_pc%0d", i), pc, 32'h4000_0300);
      check($sformatf("stl_fl%0d", i), {31'd0, flush}, 32'd1);
      tick();
    end
    stall = 0; #1;
    check("unstl_pc0", pc, 32'h4000_0300);
    check("unstl_fl0", {31'd0, flush}, 32'd1);
    tick();
    check("unstl_pc1", pc, 32'h4000_0304);
    check("unstl_fl1", {31'd0, flush}, 32'd1);
    tick();
    check("unstl_pc2", pc, 32'h4000_0308);
    check("unstl_fl2", {31'd0, flush}, 32'd0);

    // BEQ taken, reset during first flush cycle, JAL held during reset
    ex(1, 0, 0, 3'b000, 1, 0, 32'h4000_0400);
    check("beq_redir", {31'd0, redirect}, 32'd1);
    tick(); idle();
    check("beq_pc", pc, 32'h4000_0400);
    check("beq_fl", {31'd0, flush}, 32'd1);
    rst = 1;
    tick();
    ex(0, 1, 0, 3'b000, 0, 0, 32'h4000_0902);
    check("rstff_pc", pc, 32'h4000_0000);
    check("rstff_fl", {31'd0, flush}, 32'd0);
    check("rst_redir", {31'd0, redirect}, 32'd0);
    check("rst_mis", {31'd0, misalign}, 32'd0);
    tick(); idle();
    rst = 0; #1;
    check("rst2_pc", pc, 32'h4000_0000);
    check("rst2_fl", {31'd0, flush}, 32'd0);
    chk_stats("rst2", 0, 0);
    tick();
    check("rst2_pc1", pc, 32'h4000_0004);
    check("rst2_fl1", {31'd0, flush}, 32'd0);

    // Remaining funct3 decodes and bubble handling
    ex(1, 0, 0, 3'b001, 1, 0, 32'h4000_0A00);
    check("bne_nt", {31'd0, redirect}, 32'd0);
    tick();
    ex(1, 0, 0, 3'b010, 1, 1, 32'h4000_0A00);
    check("f010_nt", {31'd0, redirect}, 32'd0);
    check("f010_brun", {31'd0, brun}, 32'd1);
    tick(); idle();
    ex(0, 1, 0, 3'b000, 0, 0, 32'h4000_0A00);
    ex_valid = 0; #1;
    check("bubble_nt", {31'd0, redirect}, 32'd0);
    tick();
    check("nt_pc", pc, 32'h4000_0010);
    chk_stats("nt", 2, 0);
    ex(1, 0, 0, 3'b101, 0, 0, 32'h4000_0B00);
    check("bge_redir", {31'd0, redirect}, 32'd1);
    tick(); idle();
    check("bge_pc", pc, 32'h4000_0B00);
    chk_stats("bge", 3, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
